fpu_wb_sequencer: RTL and testbench
===================================

// Module: fpu_wb_sequencer
// PURPOSE
//   Issue/write-back sequencer for the FPU datapath, directly upstream of the registered result mux.
//   - Accepts one decoded FP operation at a time.
//   - Drives the 4-bit result-select code to the mux for the unit's latency.
//   - Pulses a start strobe to the selected unit.
//   - Asserts an FP register-file write enable in the cycle the mux output (zout) holds the result.
// PARAMETERS
//   LAT_ADD  1  cycles for add.s/add.ps/sub.s/sub.ps results to be valid (>=1)
//   LAT_MUL  2  cycles for mul.s/mul.ps (>=1)
//   LAT_DIV  8  cycles for div.s (>=1)
//   LAT_CVT  1  cycles for cvt.*, pll/pul-style converts, mtc1 (>=1)
//   RA_W     5  FP register address width
// PORTS
//   clk       in   1     clock, all logic on rising edge
//   rst       in   1     synchronous reset, active-high
//   in_valid  in   1     op request valid
//   in_ready  out  1     sequencer can accept (IDLE)
//   in_op     in   4     op code, same encoding as mux select (0001 add.s .. 1011 cvt.s.pu, 1111 mtc1)
//   in_fd     in   RA_W  destination FP register
//   unit_start out 1     one-cycle start pulse to the unit selected by sel
//   sel       out  4     result-mux select
//   wb_en     out  1     FP regfile write enable
//   wb_addr   out  RA_W  FP regfile write address
//   busy      out  1     high in EXEC and WB
//   err_op    out  1     one-cycle pulse: illegal op accepted and dropped
// BEHAVIOUR
//   Reset values: in_ready=0 while rst high, then 1. All other outputs 0. FSM=IDLE.
//   Reset mid-operation aborts: no wb_en is issued for the aborted op.
//   Legal ops: 0001-1011 and 1111. Illegal ops: 0000 and 1100-1110.
//   Latency class per op:
//     - 0001-0100 -> LAT_ADD
//     - 0101/0110 -> LAT_MUL
//     - 0111 -> LAT_DIV
//     - 1000-1011, 1111 -> LAT_CVT
//   IDLE: in_ready=1, sel=0, busy=0.
//     - in_valid & legal at edge T: latch op->op_q, fd->fd_q. cnt<=L-1. Go EXEC.
//     - in_valid & illegal: err_op=1 in cycle T+1. Stay IDLE. Nothing latched.
//   EXEC (cycles T+1..T+L): sel=op_q, in_ready=0, busy=1.
//     - unit_start=1 only in cycle T+1.
//     - cnt==0 -> WB, else cnt<=cnt-1.
//     - The mux captures the unit result at the end of cycle T+L.
//   WB (cycle T+L+1): wb_en=1, wb_addr=fd_q, sel=op_q held, busy=1, in_ready=0. Next state IDLE.
//   Throughput: one op per L+2 cycles. in_valid while busy is ignored (not queued); the requester must hold it.
//   wb_addr=0 and sel=0 whenever wb_en=0 / FSM=IDLE.
//   cnt width = $clog2(max latency)+1. No wrap: cnt is only decremented while nonzero.
//   Registered outputs only; no combinational in->out paths except in_ready (from state).
// STRUCTURE
//   Shared package fpu_pkg holds:
//     - the 4-bit op/select constants (OP_ADDS..OP_MTC1), shared with the result mux and decoder;
//     - the FSM state typedef {IDLE, EXEC, WB};
//     - the RA_W default.
//   One natural sub-module: fpu_op_lat, combinational op -> {legal, latency}.
//   FSM, counter and output registers stay in this module.
// TESTING
//   1. rst=1 for 3 clk with in_valid=1, in_op=0001 -> all outputs 0, in_ready=0. After release: in_ready=1, no op accepted during reset.
//   2. add.s (0001, fd=3), LAT_ADD=1, accepted at T -> unit_start and sel=0001 @T+1; wb_en=1, wb_addr=3 @T+2; in_ready=1 @T+3.
//   3. div.s (0111, fd=31) -> sel=0111 for 9 cycles (T+1..T+9); wb_en only @T+9. in_valid with in_op=0001 held during T+1..T+9 is accepted at T+10, not earlier.
//   4. in_op=1100 then 0000 -> err_op pulses each time, sel stays 0, wb_en never asserted, in_ready stays 1.
//   5. mul.ps (0110), rst asserted @T+2 -> wb_en never asserted. @T+3: sel=0, in_ready=0, busy=0. In_ready=1 after release.
//   6. Back-to-back mtc1 (1111, fd=7) then cvt (1000, fd=8) with in_valid held -> wb_en @T+2 (addr 7) and @T+5 (addr 8), sel=1111 then 1000.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: op/result-select codes, sequencer state type and defaults.
// Also used by the result mux and decoder.
package fpu_pkg;

  localparam int unsigned RA_W_DEF = 5;

  localparam logic [3:0] OP_NONE   = 4'b0000;
  localparam logic [3:0] OP_ADDS   = 4'b0001;
  localparam logic [3:0] OP_ADDPS  = 4'b0010;
  localparam logic [3:0] OP_SUBS   = 4'b0011;
  localparam logic [3:0] OP_SUBPS  = 4'b0100;
  localparam logic [3:0] OP_MULS   = 4'b0101;
  localparam logic [3:0] OP_MULPS  = 4'b0110;
  localparam logic [3:0] OP_DIVS   = 4'b0111;
  localparam logic [3:0] OP_CVTS   = 4'b1000;
  localparam logic [3:0] OP_CVTW   = 4'b1001;
  localparam logic [3:0] OP_CVTSPL = 4'b1010;
  localparam logic [3:0] OP_CVTSPU = 4'b1011;
  localparam logic [3:0] OP_MTC1   = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fpu_wb_sequencer_op_lat.sv
// Combinational op decode: legality and result latency of the selected unit.
module fpu_op_lat
  import fpu_pkg::*;
#(
  parameter int unsigned LAT_ADD = 1,
  parameter int unsigned LAT_MUL = 2,
  parameter int unsigned LAT_DIV = 8,
  parameter int unsigned LAT_CVT = 1,
  parameter int unsigned CNT_W   = 4
) (
  input  logic [3:0]       i_op,
  output logic             o_legal,
  output logic [CNT_W-1:0] o_lat
);

  always_comb begin
    o_legal = 1'b1;
    o_lat   = '0;
    case (i_op)
      OP_ADDS, OP_ADDPS, OP_SUBS, OP_SUBPS:
        o_lat = CNT_W'(LAT_ADD);
      OP_MULS, OP_MULPS:
        o_lat = CNT_W'(LAT_MUL);
      OP_DIVS:
        o_lat = CNT_W'(LAT_DIV);
      OP_CVTS, OP_CVTW, OP_CVTSPL, OP_CVTSPU, OP_MTC1:
        o_lat = CNT_W'(LAT_CVT);
      default:
        o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/fpu_wb_sequencer.sv
// FPU issue/write-back sequencer: holds the result-mux select for the unit latency,
// pulses the unit start and raises the regfile write enable when zout holds the result.
module fpu_wb_sequencer
  import fpu_pkg::*;
#(
  parameter int unsigned LAT_ADD = 1,
  parameter int unsigned LAT_MUL = 2,
  parameter int unsigned LAT_DIV = 8,
  parameter int unsigned LAT_CVT = 1,
  parameter int unsigned RA_W    = RA_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [RA_W-1:0] in_fd,
  output logic            unit_start,
  output logic [3:0]      sel,
  output logic            wb_en,
  output logic [RA_W-1:0] wb_addr,
  output logic            busy,
  output logic            err_op
);

  localparam int unsigned MAX_LAT = max2(max2(LAT_ADD, LAT_MUL), max2(LAT_DIV, LAT_CVT));
  localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [3:0]        r_op_q;
  logic [3:0]        w_op_nxt;
  logic [RA_W-1:0]   r_fd_q;
  logic [RA_W-1:0]   w_fd_nxt;

  logic              r_unit_start;
  logic [3:0]        r_sel;
  logic              r_wb_en;
  logic [RA_W-1:0]   r_wb_addr;
  logic              r_busy;
  logic              r_err_op;

  logic              w_start_nxt;
  logic [3:0]        w_sel_nxt;
  logic              w_wb_en_nxt;
  logic [RA_W-1:0]   w_wb_addr_nxt;
  logic              w_busy_nxt;
  logic              w_err_nxt;

  logic              w_legal;
  logic [CNT_W-1:0]  w_lat;

  fpu_op_lat #(
    .LAT_ADD (LAT_ADD),
    .LAT_MUL (LAT_MUL),
    .LAT_DIV (LAT_DIV),
    .LAT_CVT (LAT_CVT),
    .CNT_W   (CNT_W)
  ) u_op_lat (
    .i_op    (in_op),
    .o_legal (w_legal),
    .o_lat   (w_lat)
  );

  // Outputs are computed one state ahead so every one of them leaves a flop.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_op_nxt      = r_op_q;
    w_fd_nxt      = r_fd_q;
    w_start_nxt   = 1'b0;
    w_sel_nxt     = '0;
    w_wb_en_nxt   = 1'b0;
    w_wb_addr_nxt = '0;
    w_busy_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          if (w_legal) begin
            w_state_nxt = EXEC;
            w_op_nxt    = in_op;
            w_fd_nxt    = in_fd;
            w_cnt_nxt   = w_lat - CNT_W'(1);
            w_start_nxt = 1'b1;
            w_sel_nxt   = in_op;
            w_busy_nxt  = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      EXEC: begin
        w_sel_nxt  = r_op_q;
        w_busy_nxt = 1'b1;
        if (r_cnt == '0) begin
          w_state_nxt   = WB;
          w_wb_en_nxt   = 1'b1;
          w_wb_addr_nxt = r_fd_q;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      WB: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_op_q       <= '0;
      r_fd_q       <= '0;
      r_unit_start <= 1'b0;
      r_sel        <= '0;
      r_wb_en      <= 1'b0;
      r_wb_addr    <= '0;
      r_busy       <= 1'b0;
      r_err_op     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_op_q       <= w_op_nxt;
      r_fd_q       <= w_fd_nxt;
      r_unit_start <= w_start_nxt;
      r_sel        <= w_sel_nxt;
      r_wb_en      <= w_wb_en_nxt;
      r_wb_addr    <= w_wb_addr_nxt;
      r_busy       <= w_busy_nxt;
      r_err_op     <= w_err_nxt;
    end
  end

  assign in_ready   = (r_state == IDLE) && !rst;
  assign unit_start = r_unit_start;
  assign sel        = r_sel;
  assign wb_en      = r_wb_en;
  assign wb_addr    = r_wb_addr;
  assign busy       = r_busy;
  assign err_op     = r_err_op;

endmodule

// File: tb/tb_fpu_wb_sequencer.sv
// Directed bench for fpu_wb_sequencer with default latencies (add 1, mul 2, div 8, cvt 1).
module tb_fpu_wb_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [4:0] in_fd;
  logic       unit_start;
  logic [3:0] sel;
  logic       wb_en;
  logic [4:0] wb_addr;
  logic       busy;
  logic       err_op;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fpu_wb_sequencer #(
    .LAT_ADD (1),
    .LAT_MUL (2),
    .LAT_DIV (8),
    .LAT_CVT (1),
    .RA_W    (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_fd      (in_fd),
    .unit_start (unit_start),
    .sel        (sel),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .busy       (busy),
    .err_op     (err_op)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic rdy, input logic st, input logic [3:0] s,
                         input logic we, input logic [4:0] wa, input logic bz, input logic er);
    chk({tag, ".in_ready"},   32'(in_ready),   32'(rdy));
    chk({tag, ".unit_start"}, 32'(unit_start), 32'(st));
    chk({tag, ".sel"},        32'(sel),        32'(s));
    chk({tag, ".wb_en"},      32'(wb_en),      32'(we));
    chk({tag, ".wb_addr"},    32'(wb_addr),    32'(wa));
    chk({tag, ".busy"},       32'(busy),       32'(bz));
    chk({tag, ".err_op"},     32'(err_op),     32'(er));
  endtask

  initial begin
    // 1: reset held 3 cycles with a legal request pending
    rst = 1'b1; in_valid = 1'b1; in_op = 4'b0001; in_fd = 5'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("rst", 0, 0, 4'h0, 0, 5'd0, 0, 0);
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk_all("rst_rel", 1, 0, 4'h0, 0, 5'd0, 0, 0);
    tick();
    chk_all("rst_idle", 1, 0, 4'h0, 0, 5'd0, 0, 0);

    // 2: add.s fd=3
    in_valid = 1'b1; in_op = 4'b0001; in_fd = 5'd3;
    tick();
    in_valid = 1'b0;
    chk_all("add_t1", 0, 1, 4'b0001, 0, 5'd0, 1, 0);
    tick();
    chk_all("add_t2", 0, 0, 4'b0001, 1, 5'd3, 1, 0);
    tick();
    chk_all("add_t3", 1, 0, 4'h0, 0, 5'd0, 0, 0);

    // 3: div.s fd=31 with a following add.s held from T+1
    in_valid = 1'b1; in_op = 4'b0111; in_fd = 5'd31;
    tick();
    in_op = 4'b0001; in_fd = 5'd2;
    for (int i = 1; i <= 9; i++) begin
      chk_all($sformatf("div_t%0d", i), 0, (i == 1), 4'b0111, (i == 9),
              (i == 9) ? 5'd31 : 5'd0, 1, 0);
      tick();
    end
    chk_all("div_t10", 1, 0, 4'h0, 0, 5'd0, 0, 0);
    tick();
    in_valid = 1'b0;
    chk_all("div_next_t11", 0, 1, 4'b0001, 0, 5'd0, 1, 0);
    tick();
    chk_all("div_next_wb", 0, 0, 4'b0001, 1, 5'd2, 1, 0);
    tick();
    chk_all("div_next_idle", 1, 0, 4'h0, 0, 5'd0, 0, 0);

    // 4: illegal ops 1100 then 0000
    in_valid = 1'b1; in_op = 4'b1100; in_fd = 5'd4;
    tick();
    in_op = 4'b0000;
    chk_all("ill_1100", 1, 0, 4'h0, 0, 5'd0, 0, 1);
    tick();
    in_valid = 1'b0;
    chk_all("ill_0000", 1, 0, 4'h0, 0, 5'd0, 0, 1);
    tick();
    chk_all("ill_after", 1, 0, 4'h0, 0, 5'd0, 0, 0);

    // 5: mul.ps aborted by reset in cycle T+2
    in_valid = 1'b1; in_op = 4'b0110; in_fd = 5'd9;
    tick();
    in_valid = 1'b0;
    chk_all("mul_t1", 0, 1, 4'b0110, 0, 5'd0, 1, 0);
    tick();
    chk_all("mul_t2", 0, 0, 4'b0110, 0, 5'd0, 1, 0);
    rst = 1'b1;
    tick();
    chk_all("mul_rst_t3", 0, 0, 4'h0, 0, 5'd0, 0, 0);
    tick();
    chk_all("mul_rst_t4", 0, 0, 4'h0, 0, 5'd0, 0, 0);
    rst = 1'b0;
    #1;
    chk("mul_rel.in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("mul_post%0d", i), 1, 0, 4'h0, 0, 5'd0, 0, 0);
    end

    // 6: mtc1 fd=7 then cvt fd=8 with in_valid held
    in_valid = 1'b1; in_op = 4'b1111; in_fd = 5'd7;
    tick();
    in_op = 4'b1000; in_fd = 5'd8;
    chk_all("b2b_t1", 0, 1, 4'b1111, 0, 5'd0, 1, 0);
    tick();
    chk_all("b2b_t2", 0, 0, 4'b1111, 1, 5'd7, 1, 0);
    tick();
    chk_all("b2b_t3", 1, 0, 4'h0, 0, 5'd0, 0, 0);
    tick();
    in_valid = 1'b0;
    chk_all("b2b_t4", 0, 1, 4'b1000, 0, 5'd0, 1, 0);
    tick();
    chk_all("b2b_t5", 0, 0, 4'b1000, 1, 5'd8, 1, 0);
    tick();
    chk_all("b2b_t6", 1, 0, 4'h0, 0, 5'd0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
